// File: rtl/flowline_pkg.sv
// ============================================================================
// Module : flowline_pkg
// Brief  : Shared encodings for the flowline CPU hazard controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package flowline_pkg;

  localparam logic [1:0] FWD_RF     = 2'b00;
  localparam logic [1:0] FWD_EXALU  = 2'b01;
  localparam logic [1:0] FWD_MEMALU = 2'b10;
  localparam logic [1:0] FWD_MEMLD  = 2'b11;

  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_J    = 2'b10;
  localparam logic [1:0] PCSRC_ILL  = 2'b11;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/fwd_sel.sv
// ============================================================================
// Module : fwd_sel
// Brief  : Operand forwarding select for one ID-stage source register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fwd_sel
  import flowline_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] r_i,
  input  logic                  use_i,
  input  logic [REG_ADDR_W-1:0] ex_rn_i,
  input  logic                  ex_wreg_i,
  input  logic                  ex_m2reg_i,
  input  logic [REG_ADDR_W-1:0] mem_rn_i,
  input  logic                  mem_wreg_i,
  input  logic                  mem_m2reg_i,
  output logic [1:0]            sel_o
);

  // A load in EX has no data yet, so it falls through to the MEM check.
  always_comb begin
    sel_o = FWD_RF;
    if (use_i && (r_i != '0)) begin
      if (ex_wreg_i && !ex_m2reg_i && (ex_rn_i == r_i)) begin
        sel_o = FWD_EXALU;
      end else if (mem_wreg_i && (mem_rn_i == r_i)) begin
        sel_o = mem_m2reg_i ? FWD_MEMLD : FWD_MEMALU;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module : pipeline_hazard_ctrl
// Brief  : Forwarding, load-use stall, branch flush and illegal-opcode halt
//          for the 5-stage flowline CPU. Define PERF_CNT_EN for counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
  import flowline_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  Clk,
  input  logic                  Clrn,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rn,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic                  id_wreg,
  input  logic                  id_m2reg,
  input  logic [1:0]            id_pcsource,
  output logic [1:0]            fwda,
  output logic [1:0]            fwdb,
  output logic                  wpcir,
  output logic                  bubble,
  output logic                  flush_if,
  output logic                  halt
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt
`endif
);

  state_e                  state_q, state_d;
  logic [REG_ADDR_W-1:0]   ex_rn_q, ex_rn_d, mem_rn_q;
  logic                    ex_wreg_q, ex_wreg_d, mem_wreg_q;
  logic                    ex_m2reg_q, ex_m2reg_d, mem_m2reg_q;
  logic                    stall;

  fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .r_i         (id_rs),
    .use_i       (id_use_rs),
    .ex_rn_i     (ex_rn_q),
    .ex_wreg_i   (ex_wreg_q),
    .ex_m2reg_i  (ex_m2reg_q),
    .mem_rn_i    (mem_rn_q),
    .mem_wreg_i  (mem_wreg_q),
    .mem_m2reg_i (mem_m2reg_q),
    .sel_o       (fwda)
  );

  fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .r_i         (id_rt),
    .use_i       (id_use_rt),
    .ex_rn_i     (ex_rn_q),
    .ex_wreg_i   (ex_wreg_q),
    .ex_m2reg_i  (ex_m2reg_q),
    .mem_rn_i    (mem_rn_q),
    .mem_wreg_i  (mem_wreg_q),
    .mem_m2reg_i (mem_m2reg_q),
    .sel_o       (fwdb)
  );

  assign stall = ex_wreg_q & ex_m2reg_q & (ex_rn_q != '0) &
                 ((id_use_rs & (ex_rn_q == id_rs)) |
                  (id_use_rt & (ex_rn_q == id_rt)));

  // A stalled branch or illegal opcode is re-decided next cycle.
  always_comb begin
    state_d  = state_q;
    wpcir    = 1'b1;
    bubble   = 1'b0;
    flush_if = 1'b0;
    halt     = 1'b0;
    case (state_q)
      RUN: begin
        if (stall) begin
          wpcir  = 1'b0;
          bubble = 1'b1;
        end else begin
          if (id_pcsource == PCSRC_ILL) state_d = HALT;
          flush_if = (id_pcsource == PCSRC_BR) || (id_pcsource == PCSRC_J);
        end
      end
      HALT: begin
        wpcir  = 1'b0;
        bubble = 1'b1;
        halt   = 1'b1;
      end
    endcase
  end

  always_comb begin
    ex_rn_d    = bubble ? '0   : id_rn;
    ex_wreg_d  = bubble ? 1'b0 : id_wreg;
    ex_m2reg_d = bubble ? 1'b0 : id_m2reg;
  end

  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      state_q     <= RUN;
      ex_rn_q     <= '0;
      ex_wreg_q   <= 1'b0;
      ex_m2reg_q  <= 1'b0;
      mem_rn_q    <= '0;
      mem_wreg_q  <= 1'b0;
      mem_m2reg_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ex_rn_q     <= ex_rn_d;
      ex_wreg_q   <= ex_wreg_d;
      ex_m2reg_q  <= ex_m2reg_d;
      mem_rn_q    <= ex_rn_q;
      mem_wreg_q  <= ex_wreg_q;
      mem_m2reg_q <= ex_m2reg_q;
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (state_q == RUN) begin
      if (stall)    stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_if) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// Module : tb_pipeline_hazard_ctrl
// Brief  : Scoreboard bench for pipeline_hazard_ctrl with directed vectors.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

  logic       Clk = 1'b0;
  logic       Clrn = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rn = '0;
  logic       id_use_rs = 1'b0, id_use_rt = 1'b0, id_wreg = 1'b0, id_m2reg = 1'b0;
  logic [1:0] id_pcsource = 2'b00;
  logic [1:0] fwda, fwdb;
  logic       wpcir, bubble, flush_if, halt;
`ifdef PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  pipeline_hazard_ctrl #(.REG_ADDR_W(5)) dut (
    .Clk         (Clk),
    .Clrn        (Clrn),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rn       (id_rn),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_wreg     (id_wreg),
    .id_m2reg    (id_m2reg),
    .id_pcsource (id_pcsource),
    .fwda        (fwda),
    .fwdb        (fwdb),
    .wpcir       (wpcir),
    .bubble      (bubble),
    .flush_if    (flush_if),
    .halt        (halt)
`ifdef PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        wp;
    logic        bub;
    logic        fl;
    logic        ht;
    bit          cc;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: outputs are stable by the falling edge of the cycle they belong to.
  always @(negedge Clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (fwda !== e.fa || fwdb !== e.fb || wpcir !== e.wp || bubble !== e.bub ||
          flush_if !== e.fl || halt !== e.ht) begin
        errors++;
        $display("FAIL %s: got fwda=%b fwdb=%b wpcir=%b bubble=%b flush_if=%b halt=%b; exp fwda=%b fwdb=%b wpcir=%b bubble=%b flush_if=%b halt=%b",
                 e.name, fwda, fwdb, wpcir, bubble, flush_if, halt,
                 e.fa, e.fb, e.wp, e.bub, e.fl, e.ht);
      end
`ifdef PERF_CNT_EN
      if (e.cc) begin
        checks++;
        if (stall_cnt !== e.sc || flush_cnt !== e.fc) begin
          errors++;
          $display("FAIL %s_cnt: got stall_cnt=%0d flush_cnt=%0d; exp stall_cnt=%0d flush_cnt=%0d",
                   e.name, stall_cnt, flush_cnt, e.sc, e.fc);
        end
      end
`endif
    end
  end

  task automatic drv(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rn,
                     input logic urs, input logic urt, input logic wr, input logic m2,
                     input logic [1:0] pcs);
    @(posedge Clk);
    #1;
    id_rs = rs; id_rt = rt; id_rn = rn;
    id_use_rs = urs; id_use_rt = urt; id_wreg = wr; id_m2reg = m2;
    id_pcsource = pcs;
  endtask

  task automatic chk(input string n, input logic [1:0] fa, input logic [1:0] fb,
                     input logic wp, input logic bub, input logic fl, input logic ht,
                     input bit cc = 1'b0, input logic [31:0] sc = '0,
                     input logic [31:0] fc = '0);
    exp_t e;
    e.name = n; e.fa = fa; e.fb = fb; e.wp = wp; e.bub = bub; e.fl = fl; e.ht = ht;
    e.cc = cc; e.sc = sc; e.fc = fc;
    q.push_back(e);
  endtask

  initial begin
    repeat (3) @(posedge Clk);
    #1;
    Clrn = 1'b1;
    chk("reset", 2'b00, 2'b00, 1, 0, 0, 0);

    // Forwarding from EX, MEM and both
    drv(1, 2, 3, 1, 1, 1, 0, 2'b00); chk("add_r3_idle", 2'b00, 2'b00, 1, 0, 0, 0);
    drv(3, 4, 0, 1, 1, 0, 0, 2'b00); chk("ex_fwd",      2'b01, 2'b00, 1, 0, 0, 0);
    drv(3, 4, 0, 1, 1, 0, 0, 2'b00); chk("mem_fwd",     2'b10, 2'b00, 1, 0, 0, 0);
    drv(0, 0, 3, 0, 0, 1, 0, 2'b00); chk("r3_again",    2'b00, 2'b00, 1, 0, 0, 0);
    drv(0, 0, 3, 0, 0, 1, 0, 2'b00);
    drv(3, 3, 0, 1, 1, 0, 0, 2'b00); chk("ex_prio",     2'b01, 2'b01, 1, 0, 0, 0);

    // Load-use on rt
    drv(1, 0, 5, 1, 0, 1, 1, 2'b00); chk("lw_issue",    2'b00, 2'b00, 1, 0, 0, 0);
    drv(1, 5, 6, 1, 1, 1, 0, 2'b00); chk("lu_stall",    2'b00, 2'b00, 0, 1, 0, 0);
    drv(1, 5, 6, 1, 1, 1, 0, 2'b00); chk("lu_fwd",      2'b00, 2'b11, 1, 0, 0, 0);

    // Register 0 never forwards nor stalls
    drv(0, 0, 0, 0, 0, 0, 0, 2'b00);
    drv(0, 0, 0, 0, 0, 1, 1, 2'b00);
    drv(0, 0, 0, 1, 1, 0, 0, 2'b00); chk("r0_ex",       2'b00, 2'b00, 1, 0, 0, 0);
    drv(0, 0, 0, 1, 1, 0, 0, 2'b00); chk("r0_mem",      2'b00, 2'b00, 1, 0, 0, 0);

    // Branch flush, plain and behind a load-use stall
    drv(1, 2, 0, 1, 1, 0, 0, 2'b01); chk("br_flush",    2'b00, 2'b00, 1, 0, 1, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 2'b00); chk("br_once",     2'b00, 2'b00, 1, 0, 0, 0);
    drv(0, 0, 7, 0, 0, 1, 1, 2'b00); chk("lw7",         2'b00, 2'b00, 1, 0, 0, 0);
    drv(7, 1, 0, 1, 1, 0, 0, 2'b01); chk("br_stall",    2'b00, 2'b00, 0, 1, 0, 0);
    drv(7, 1, 0, 1, 1, 0, 0, 2'b01); chk("br_after",    2'b11, 2'b00, 1, 0, 1, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 2'b00);

    // Illegal opcode behind a stall, then halt and shadow drain
    drv(0, 0, 8, 0, 0, 1, 1, 2'b00);
    drv(8, 0, 9, 1, 0, 1, 0, 2'b11); chk("ill_stall",   2'b00, 2'b00, 0, 1, 0, 0);
    drv(8, 0, 9, 1, 0, 1, 0, 2'b11); chk("ill_run",     2'b11, 2'b00, 1, 0, 0, 0);
    drv(9, 0, 0, 1, 0, 0, 0, 2'b01); chk("halt_ex",     2'b01, 2'b00, 0, 1, 0, 1);
    drv(9, 0, 9, 1, 0, 1, 0, 2'b00); chk("halt_mem",    2'b10, 2'b00, 0, 1, 0, 1);
    drv(9, 0, 9, 1, 0, 1, 0, 2'b00); chk("halt_drain",  2'b00, 2'b00, 0, 1, 0, 1);
    @(posedge Clk);
    #1;
    Clrn = 1'b0;
    drv(3, 3, 0, 1, 1, 0, 0, 2'b00);
    Clrn = 1'b1;
    chk("halt_reset", 2'b00, 2'b00, 1, 0, 0, 0);

    // Reset asserted during a stall cycle
    drv(0, 0, 4, 0, 0, 1, 1, 2'b00);
    drv(4, 0, 0, 1, 0, 0, 0, 2'b00);
    Clrn = 1'b0;
    chk("rst_stall_pre", 2'b00, 2'b00, 0, 1, 0, 0);
    drv(4, 0, 0, 1, 0, 0, 0, 2'b00);
    Clrn = 1'b1;
    chk("rst_mid_stall", 2'b00, 2'b00, 1, 0, 0, 0);

    // Jumps and load-use stalls for the event counters
    drv(0, 0, 0, 0, 0, 0, 0, 2'b10); chk("jump",        2'b00, 2'b00, 1, 0, 1, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 2'b00); chk("cnt1",        2'b00, 2'b00, 1, 0, 0, 0, 1'b1, 32'd0, 32'd1);
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 5'(10 + i), 0, 0, 1, 1, 2'b00);
      drv(0, 5'(10 + i), 0, 0, 1, 0, 0, 2'b00); chk("loop_stall", 2'b00, 2'b00, 0, 1, 0, 0);
      drv(0, 5'(10 + i), 0, 0, 1, 0, 0, 2'b00); chk("loop_fwd",   2'b00, 2'b11, 1, 0, 0, 0);
    end
    drv(0, 0, 0, 0, 0, 0, 0, 2'b10); chk("jump2",       2'b00, 2'b00, 1, 0, 1, 0);
    drv(0, 0, 14, 0, 0, 1, 1, 2'b11); chk("ill_ld",     2'b00, 2'b00, 1, 0, 0, 0, 1'b1, 32'd3, 32'd2);
    drv(14, 0, 0, 1, 0, 0, 0, 2'b01); chk("halt_stall", 2'b00, 2'b00, 0, 1, 0, 1, 1'b1, 32'd3, 32'd2);
    drv(14, 0, 0, 1, 0, 0, 0, 2'b01); chk("halt_freeze", 2'b11, 2'b00, 0, 1, 0, 1, 1'b1, 32'd3, 32'd2);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge Clk);
    @(posedge Clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
